// File: rtl/checkout_arbiter.sv
// Multi-lane checkout totaliser: N lanes share one W-bit adder through a
// round-robin arbiter (IDLE -> LOAD -> ADD), each lane keeps a sum, total and overflow flag.
module checkout_arbiter #(
   parameter int W = 5,
   parameter int N = 4
) (
   input  logic           Clock,
   input  logic           Reset_n,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   T,
   input  logic [N-1:0]   C,
   input  logic [N*W-1:0] X,
   output logic [N-1:0]   Grant,
   output logic [N*W-1:0] Total,
   output logic [N-1:0]   Ovf,
   output logic           Busy
);

   localparam int LW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {ARB_IDLE, ARB_LOAD, ARB_ADD} arb_state_t;
   typedef enum logic [1:0] {LS_IDLE, LS_ACCUM, LS_DISPLAY} lane_state_t;

   arb_state_t      arb_state_reg;
   logic [W-1:0]    areg_reg;
   logic [LW-1:0]   lid_reg;
   logic [LW-1:0]   p_reg;
   logic [N-1:0]    grant_reg;
   logic            busy_reg;
   logic            ready_reg;

   logic [N-1:0]    eligible;
   logic [N*W-1:0]  s_flat;
   logic [W-1:0]    s_sel;
   logic [W-1:0]    x_sel;
   logic [W:0]      sum;
   logic            pick_valid;
   logic [LW-1:0]   pick_lid;
   int              idx;

   assign s_sel = s_flat[lid_reg*W +: W];
   assign x_sel = X[lid_reg*W +: W];
   assign sum   = {1'b0, s_sel} + {1'b0, areg_reg};

   // Scan downward so the last hit is the first eligible lane at or after P.
   always_comb begin
      pick_valid = 1'b0;
      pick_lid   = '0;
      idx        = 0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(p_reg) + i) % N;
         if (eligible[idx]) begin
            pick_valid = 1'b1;
            pick_lid   = LW'(idx);
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         arb_state_reg <= ARB_IDLE;
         areg_reg      <= '0;
         lid_reg       <= '0;
         p_reg         <= '0;
         grant_reg     <= '0;
         busy_reg      <= 1'b0;
         ready_reg     <= 1'b0;
      end else begin
         ready_reg <= 1'b1;
         grant_reg <= '0;
         case (arb_state_reg)
            ARB_IDLE: begin
               if (ready_reg && pick_valid) begin
                  lid_reg       <= pick_lid;
                  grant_reg     <= {{(N-1){1'b0}}, 1'b1} << pick_lid;
                  arb_state_reg <= ARB_LOAD;
                  busy_reg      <= 1'b1;
               end
            end
            ARB_LOAD: begin
               areg_reg      <= x_sel;
               arb_state_reg <= ARB_ADD;
            end
            ARB_ADD: begin
               p_reg         <= (lid_reg == LW'(N - 1)) ? '0 : lid_reg + 1'b1;
               arb_state_reg <= ARB_IDLE;
               busy_reg      <= 1'b0;
            end
            default: begin
               arb_state_reg <= ARB_IDLE;
               busy_reg      <= 1'b0;
            end
         endcase
      end
   end

   assign Grant = grant_reg;
   assign Busy  = busy_reg;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_lane
         lane_state_t  ls_reg;
         logic [W-1:0] s_reg;
         logic [W-1:0] total_reg;
         logic         ovf_reg;
         logic         lane_busy;

         // A lane owning the adder cannot display; its total waits for the write-back.
         assign lane_busy     = (arb_state_reg != ARB_IDLE) && (lid_reg == LW'(gi));
         assign eligible[gi]  = A[gi] && (ls_reg != LS_DISPLAY);

         always_ff @(posedge Clock or negedge Reset_n) begin
            if (!Reset_n) begin
               ls_reg    <= LS_IDLE;
               s_reg     <= '0;
               total_reg <= '0;
               ovf_reg   <= 1'b0;
            end else if (ls_reg == LS_DISPLAY) begin
               if (C[gi]) begin
                  s_reg     <= '0;
                  total_reg <= '0;
                  ovf_reg   <= 1'b0;
                  ls_reg    <= LS_IDLE;
               end
            end else begin
               if (arb_state_reg == ARB_LOAD && lane_busy)
                  ls_reg <= LS_ACCUM;
               if (arb_state_reg == ARB_ADD && lane_busy) begin
                  s_reg <= sum[W-1:0];
                  if (sum[W])
                     ovf_reg <= 1'b1;
               end
               if (ls_reg == LS_ACCUM && T[gi] && !A[gi] && !lane_busy) begin
                  total_reg <= s_reg;
                  ls_reg    <= LS_DISPLAY;
               end
            end
         end

         assign s_flat[gi*W +: W] = s_reg;
         assign Total[gi*W +: W]  = total_reg;
         assign Ovf[gi]           = ovf_reg;
      end
   endgenerate

endmodule

// File: tb/tb_checkout_arbiter.sv
// Scoreboard bench for checkout_arbiter: expected grant lanes are queued when
// a request is raised and popped whenever the DUT pulses Grant.
module tb_checkout_arbiter;
   localparam int W = 5;
   localparam int N = 4;

   logic           Clock = 1'b0;
   logic           Reset_n;
   logic [N-1:0]   A, T, C;
   logic [N*W-1:0] X;
   logic [N-1:0]   Grant;
   logic [N*W-1:0] Total;
   logic [N-1:0]   Ovf;
   logic           Busy;

   int tests_run    = 0;
   int tests_failed = 0;
   int grant_q[$];
   int grant_seen   = 0;
   int exp_lane;
   int ms[N];
   int mo[N];

   checkout_arbiter #(.W(W), .N(N)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .A(A), .T(T), .C(C), .X(X),
      .Grant(Grant), .Total(Total), .Ovf(Ovf), .Busy(Busy)
   );

   always #5 Clock = ~Clock;

   task automatic check_val(input string tag, input int obs, input int exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end else begin
         $display("[TB] ok %s = %0d", tag, obs);
      end
   endtask

   // Every Grant pulse must match the next queued lane.
   always @(negedge Clock) begin
      if (Grant != '0) begin
         grant_seen++;
         if (grant_q.size() == 0) begin
            check_val("unexpected_grant", int'(Grant), 0);
         end else begin
            exp_lane = grant_q.pop_front();
            check_val("grant_lane", int'(Grant), 1 << exp_lane);
         end
      end
   end

   task automatic model_add(input int lane, input int val);
      int s;
      s = ms[lane] + val;
      if (s >= (1 << W)) mo[lane] = 1;
      ms[lane] = s % (1 << W);
   endtask

   task automatic clear_model();
      for (int k = 0; k < N; k++) begin
         ms[k] = 0;
         mo[k] = 0;
      end
   endtask

   task automatic wait_grant(input int lane);
      int n;
      n = 0;
      do begin
         @(negedge Clock);
         n++;
      end while (!Grant[lane] && n < 20);
      if (!Grant[lane]) check_val($sformatf("grant_timeout%0d", lane), 0, 1);
      A[lane] = 1'b0;
   endtask

   task automatic add_op(input int lane, input int val);
      X[lane*W +: W] = W'(val);
      A[lane] = 1'b1;
      grant_q.push_back(lane);
      model_add(lane, val);
      wait_grant(lane);
      repeat (2) @(negedge Clock);
   endtask

   task automatic show_total(input int lane);
      T[lane] = 1'b1;
      repeat (4) @(negedge Clock);
      T[lane] = 1'b0;
      check_val($sformatf("total%0d", lane), int'(Total[lane*W +: W]), ms[lane]);
      check_val($sformatf("ovf%0d", lane), int'(Ovf[lane]), mo[lane]);
   endtask

   task automatic clear_lane(input int lane);
      C[lane] = 1'b1;
      repeat (2) @(negedge Clock);
      C[lane] = 1'b0;
      ms[lane] = 0;
      mo[lane] = 0;
      check_val($sformatf("clr_total%0d", lane), int'(Total[lane*W +: W]), 0);
      check_val($sformatf("clr_ovf%0d", lane), int'(Ovf[lane]), 0);
   endtask

   initial begin
      int g0, n, last;
      A = '0; T = '0; C = '0; X = '0;
      Reset_n = 1'b0;
      clear_model();

      // Single lane: request is already up during reset.
      X[0*W +: W] = W'(3);
      A[0] = 1'b1;
      repeat (3) @(negedge Clock);
      check_val("rst_grant", int'(Grant), 0);
      check_val("rst_busy", int'(Busy), 0);
      check_val("rst_total", int'(Total), 0);
      check_val("rst_ovf", int'(Ovf), 0);
      grant_q.push_back(0);
      model_add(0, 3);
      Reset_n = 1'b1;
      @(negedge Clock);
      check_val("early_grant", int'(Grant), 0);
      wait_grant(0);
      repeat (2) @(negedge Clock);
      add_op(0, 7);
      add_op(0, 4);
      show_total(0);

      // A ignored while lane is displaying.
      g0 = grant_seen;
      X[0*W +: W] = W'(9);
      A[0] = 1'b1;
      repeat (8) @(negedge Clock);
      A[0] = 1'b0;
      check_val("display_no_grant", grant_seen - g0, 0);
      clear_lane(0);

      // C ignored in ACCUM.
      add_op(3, 5);
      C[3] = 1'b1;
      repeat (3) @(negedge Clock);
      C[3] = 1'b0;
      show_total(3);
      clear_lane(3);

      // Overflow is sticky until cleared in DISPLAY.
      add_op(2, 20);
      add_op(2, 15);
      check_val("ovf2_set", int'(Ovf[2]), 1);
      add_op(2, 1);
      show_total(2);
      clear_lane(2);

      // A and T together: add first, total only after write-back.
      add_op(1, 2);
      X[1*W +: W] = W'(6);
      A[1] = 1'b1;
      T[1] = 1'b1;
      grant_q.push_back(1);
      model_add(1, 6);
      wait_grant(1);
      check_val("sim_hold_load", int'(Total[1*W +: W]), 0);
      @(negedge Clock);
      check_val("sim_hold_add", int'(Total[1*W +: W]), 0);
      repeat (3) @(negedge Clock);
      T[1] = 1'b0;
      check_val("sim_total1", int'(Total[1*W +: W]), ms[1]);

      // Reset while the arbiter is in ARB_ADD.
      X[0*W +: W] = W'(9);
      A[0] = 1'b1;
      grant_q.push_back(0);
      wait_grant(0);
      @(posedge Clock);
      #2;
      check_val("busy_in_add", int'(Busy), 1);
      Reset_n = 1'b0;
      #1;
      check_val("mid_rst_grant", int'(Grant), 0);
      check_val("mid_rst_busy", int'(Busy), 0);
      check_val("mid_rst_total", int'(Total), 0);
      check_val("mid_rst_ovf", int'(Ovf), 0);
      clear_model();
      @(negedge Clock);
      Reset_n = 1'b1;

      // Contention from P=0: order 0,1,2,3,0, three cycles apart.
      for (int k = 0; k < N; k++) X[k*W +: W] = W'(k + 1);
      for (int k = 0; k < N; k++) begin
         grant_q.push_back(k);
         model_add(k, k + 1);
      end
      grant_q.push_back(0);
      model_add(0, 1);
      A = '1;
      n = 0;
      last = 0;
      for (int cyc = 0; cyc < 60 && n < 5; cyc++) begin
         @(negedge Clock);
         if (Grant != '0) begin
            if (n > 0) check_val("grant_gap", cyc - last, 3);
            last = cyc;
            n++;
            if (n == 5) A = '0;
         end
      end
      A = '0;
      check_val("contention_grants", n, 5);
      repeat (3) @(negedge Clock);
      show_total(0);
      show_total(1);
      show_total(3);

      check_val("sb_empty", grant_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule

// File: doc/checkout_arbiter.md
CHECKOUT_ARBITER -- requirements
Module: checkout_arbiter

Interface
REQ-001 SHALL have parameter W, default 5, which sets the operand, sum and total bit width.
REQ-002 SHALL have parameter N, default 4, which sets the number of checkout lanes sharing one adder, with N >= 2.
REQ-003 SHALL have port Clock, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 SHALL have port Reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port A, input, N bits: per-lane add request, level, held until that lane's Grant.
REQ-006 SHALL have port T, input, N bits: per-lane display-total request, level.
REQ-007 SHALL have port C, input, N bits: per-lane clear request, level.
REQ-008 SHALL have port X, input, N*W bits: unsigned per-lane operands, lane k at X[k*W +: W], stable while A[k]=1.
REQ-009 SHALL have port Grant, output, N bits: one-hot, one-cycle pulse marking the lane whose X is sampled this cycle.
REQ-010 SHALL have port Total, output, N*W bits: per-lane displayed total, lane k at Total[k*W +: W].
REQ-011 SHALL have port Ovf, output, N bits: per-lane sticky overflow flag.
REQ-012 SHALL have port Busy, output, 1 bit: 1 whenever the arbiter is not in ARB_IDLE.

Function
REQ-013 SHALL keep per lane a W-bit running sum S[k], a Total[k] register, Ovf[k], and a lane state LS[k] in {IDLE, ACCUM, DISPLAY}.
REQ-014 SHALL provide one shared W-bit unsigned adder plus operand register AREG and lane-id register LID, used by the arbiter FSM {ARB_IDLE, ARB_LOAD, ARB_ADD}.
REQ-015 SHALL treat lane k as eligible when A[k]=1 and LS[k] is IDLE or ACCUM; A[k] SHALL be ignored in DISPLAY.
REQ-016 SHALL, in ARB_IDLE with any lane eligible, pick the first eligible lane at or after round-robin pointer P, going upward and wrapping from N-1 to 0, then move to ARB_LOAD.
REQ-017 SHALL, in ARB_LOAD: assert Grant[LID]; AREG <= X[LID]; LS[LID] <= ACCUM; go to ARB_ADD.
REQ-018 SHALL, in ARB_ADD: S[LID] <= (S[LID]+AREG) mod 2^W; set Ovf[LID] if carry-out=1; P <= LID+1 mod N; go to ARB_IDLE.
REQ-019 SHALL give one add per 3 cycles per grant, with the sum visible in S the cycle after ARB_ADD.
REQ-020 SHALL NOT let Ovf clear on a later add without carry.
REQ-021 SHALL, when lane k is in ACCUM, T[k]=1, A[k]=0, and LID != k or the arbiter is in ARB_IDLE: load Total[k] <= S[k] and set LS[k] <= DISPLAY.
REQ-022 SHALL, when A[k] and T[k] are both 1 in ACCUM, serve the add first; the total follows once A[k] drops.
REQ-023 SHALL hold T[k] pending (no Total update) while lane k's add is in ARB_LOAD or ARB_ADD.
REQ-024 SHALL, in DISPLAY with C[k]=1: S[k], Total[k] and Ovf[k] <= 0; LS[k] <= IDLE. C[k] SHALL be ignored in other states.
REQ-025 SHALL hold Total[k] constant outside REQ-021 and REQ-024.
REQ-026 SHALL leave other lanes' state and arbitration unaffected by per-lane T/C actions.

Reset
REQ-027 SHALL, on Reset_n=0, asynchronously set all S, Total, Ovf, AREG, LID, Grant and Busy to 0, all LS to IDLE, the arbiter to ARB_IDLE and P to 0.
REQ-028 SHALL, on reset mid-add, discard the in-flight operand and leave no partial update.
REQ-029 SHALL give the first grant no earlier than the 2nd rising edge after Reset_n deasserts.

Verification
REQ-030 SHALL be verified for a single lane: lane0 adds 3, 7, 4 (A held until Grant), then T -> Total[0]=14, Ovf[0]=0; then C -> Total[0]=0.
REQ-031 SHALL be verified for contention: A=4'b1111 from P=0 -> Grant order 0,1,2,3,0... each 3 cycles apart; no lane is granted twice before all pending lanes are served.
REQ-032 SHALL be verified for overflow: lane2 adds 20 then 15 (W=5) -> S[2]=3, Ovf[2]=1; a later add of 1 gives S[2]=4 with Ovf[2] still 1; C in DISPLAY clears it.
REQ-033 SHALL be verified for simultaneous events: lane1 in ACCUM with A=1,T=1 -> add is granted first; Total[1] loads only after A drops and the add has written back.
REQ-034 SHALL be verified for ignored inputs: A in DISPLAY -> no Grant; C in ACCUM -> S unchanged.
REQ-035 SHALL be verified for reset in ARB_ADD: Reset_n pulsed low -> all outputs 0 immediately, with no write to S.
